// File: rtl/pin_debounce_pkg.sv
// Shared types and constants for the pad input conditioning stage.
// The event struct width is fixed here, so the top checks that its WIDTH fits.
package pin_debounce_pkg;

    localparam int CLK_MHZ               = 24;
    localparam int DEBOUNCE_US           = 1000;
    localparam int DEFAULT_STABLE_CYCLES = CLK_MHZ * DEBOUNCE_US;
    localparam int DEFAULT_WIDTH         = 4;

    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int EV_IDX_W = idx_width(DEFAULT_WIDTH);

    typedef struct packed {
        logic [EV_IDX_W-1:0] idx;
        logic                rise;
    } ev_t;

endpackage

// File: rtl/pin_debounce_bit.sv
// One pad bit: two-flop synchroniser, stability counter, debounced level and edge strobes.
// The update output goes high in the cycle before the new level is registered.
module debounce_bit
    import pin_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic update
);

    localparam int             CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    assign update = (sync_q[1] != level) && (cnt_q == CNT_MAX);

    // NOTE: non-blocking throughout, so strobes default low and the update branch overrides them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                level <= sync_q[1];
                cnt_q <= '0;
                rise  <= sync_q[1];
                fall  <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pin_debounce.sv
// Debounces WIDTH pad inputs and queues per-bit edge events through a
// round-robin arbiter into a single valid/ready output register.
module pin_debounce
    import pin_debounce_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int IDX_W         = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             ev_valid_o,
    input  logic             ev_ready_i,
    output logic [IDX_W-1:0] ev_idx_o,
    output logic             ev_rise_o,
    output logic             overflow_o
);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("pin_debounce: STABLE_CYCLES must be at least 2");
    end
    if (IDX_W != idx_width(WIDTH) || IDX_W > EV_IDX_W) begin : g_bad_idx
        $error("pin_debounce: IDX_W is derived from WIDTH and must fit ev_t");
    end

    logic [WIDTH-1:0] update;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] dir_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             load_en;
    logic             take;
    logic             ev_valid_q;
    logic             overflow_q;
    ev_t              ev_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .pin   (pin_i[i]),
            .level (level_o[i]),
            .rise  (rise_o[i]),
            .fall  (fall_o[i]),
            .update(update[i])
        );
    end

    // NOTE: every output of this block is assigned up front so no path leaves a latch.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (!sel_found && pend_q[(int'(ptr_q) + k) % WIDTH]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'((int'(ptr_q) + k) % WIDTH);
            end
        end
    end

    assign load_en = !ev_valid_q || ev_ready_i;
    assign take    = load_en && sel_found;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ev_valid_q <= 1'b0;
            ev_q       <= '0;
            ptr_q      <= '0;
        end else if (take) begin
            ev_valid_q <= 1'b1;
            ev_q.idx   <= EV_IDX_W'(sel_idx);
            ev_q.rise  <= dir_q[sel_idx];
            ptr_q      <= IDX_W'((int'(sel_idx) + 1) % WIDTH);
        end else if (load_en) begin
            ev_valid_q <= 1'b0;
        end
    end

    // A level update beats a same-cycle selection: the bit stays pending with the newer direction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q     <= '0;
            dir_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (update[i]) begin
                    pend_q[i] <= 1'b1;
                    dir_q[i]  <= ~level_o[i];
                    if (pend_q[i] && !(take && sel_idx == IDX_W'(i))) begin
                        overflow_q <= 1'b1;
                    end
                end else if (take && sel_idx == IDX_W'(i)) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    assign ev_valid_o = ev_valid_q;
    assign ev_idx_o   = IDX_W'(ev_q.idx);
    assign ev_rise_o  = ev_q.rise;
    assign overflow_o = overflow_q;

endmodule
